// File: rtl/clk_div_pkg.sv
// Shared definitions for clk_div_gen: FSM state encoding, minimum divisor,
// and the high-phase length helper.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    BURST    = 2'd3
  } div_state_e;

  localparam int DIV_MIN = 2;

  // High phase is floor(N/2) cycles; the low phase takes the remainder.
  function automatic logic [31:0] div_half(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for clk_div_gen: counts 0..N-1 while running, flags the wrap
// cycle and reports whether the next cycle falls inside the high phase.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] div_n_i,
  output logic             wrap_o,
  output logic             hi_nxt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] half;

  assign half   = CNT_W'(div_half(32'(div_n_i)));
  assign wrap_o = run_i && (cnt_q == (div_n_i - CNT_W'(1)));

  // Idle and wrap both park the counter at zero, so a start or a divisor
  // change always begins a fresh period.
  always_comb begin
    cnt_d = '0;
    if (run_i && !wrap_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign hi_nxt_o = (cnt_d < half);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Programmable integer clock divider with glitch-free start/stop and
// period-aligned divisor changes. Define CLK_DIV_BURST_EN for burst mode.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DIV_RST = 2
) (
  input  logic             Clk_C16,
  input  logic             Clk_C16_Rst_n,
  input  logic             Enable,
  input  logic [CNT_W-1:0] Div_Val,
  input  logic             Div_Load,
  output logic             Div_Ack,
  output logic [CNT_W-1:0] Div_Val_Cur,
  output logic             Clk_Div_Out,
  output logic             Clk_Div_Rise,
  output logic             Div_Active
`ifdef CLK_DIV_BURST_EN
  ,
  input  logic [CNT_W-1:0] Burst_Len,
  input  logic             Burst_Start,
  output logic             Burst_Done
`endif
);

  div_state_e       state_q, state_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             pending_q, pending_d;
  logic             upd_q, ack_q;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic [CNT_W-1:0] load_val, apply_val;
  logic             running, wrap, hi_nxt, apply;
`ifdef CLK_DIV_BURST_EN
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
`endif

  assign running  = (state_q != IDLE);
  assign load_val = (Div_Val < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : Div_Val;

  // While running, a divisor only changes at a wrap; a load landing on the
  // wrap itself is taken directly. In idle the pending value lands next cycle.
  assign apply     = running ? (wrap && (pending_q || Div_Load))
                             : (pending_q && !Div_Load);
  assign apply_val = (running && Div_Load) ? load_val : pend_val_q;
  assign cur_d      = apply ? apply_val : cur_q;
  assign pend_val_d = Div_Load ? load_val : pend_val_q;
  assign pending_d  = apply ? 1'b0 : (pending_q || Div_Load);

  clk_div_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i    (Clk_C16),
    .rst_n_i  (Clk_C16_Rst_n),
    .run_i    (running),
    .div_n_i  (cur_q),
    .wrap_o   (wrap),
    .hi_nxt_o (hi_nxt)
  );

  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    rise_d  = 1'b0;
`ifdef CLK_DIV_BURST_EN
    rem_d   = rem_q;
    done_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (Enable) begin
          state_d = RUN;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end
`ifdef CLK_DIV_BURST_EN
        else if (Burst_Start) begin
          if (Burst_Len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
            rem_d   = Burst_Len;
            out_d   = 1'b1;
            rise_d  = 1'b1;
          end
        end
`endif
      end
      RUN, STOPPING: begin
        // Re-asserting Enable before the wrap resumes without a gap.
        if (wrap && !Enable) begin
          state_d = IDLE;
        end else begin
          state_d = Enable ? RUN : STOPPING;
          out_d   = hi_nxt;
          rise_d  = wrap;
        end
      end
`ifdef CLK_DIV_BURST_EN
      BURST: begin
        if (wrap && (rem_q == CNT_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (wrap) begin
            rem_d = rem_q - CNT_W'(1);
          end
          out_d  = hi_nxt;
          rise_d = wrap;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_C16 or negedge Clk_C16_Rst_n) begin
    if (!Clk_C16_Rst_n) begin
      state_q    <= IDLE;
      out_q      <= 1'b0;
      rise_q     <= 1'b0;
      pending_q  <= 1'b0;
      upd_q      <= 1'b0;
      ack_q      <= 1'b0;
      cur_q      <= CNT_W'(DIV_RST);
      pend_val_q <= CNT_W'(DIV_RST);
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      rise_q     <= rise_d;
      pending_q  <= pending_d;
      upd_q      <= apply;
      ack_q      <= upd_q;
      cur_q      <= cur_d;
      pend_val_q <= pend_val_d;
    end
  end

`ifdef CLK_DIV_BURST_EN
  always_ff @(posedge Clk_C16 or negedge Clk_C16_Rst_n) begin
    if (!Clk_C16_Rst_n) begin
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  assign Burst_Done = done_q;
`endif

  assign Clk_Div_Out  = out_q;
  assign Clk_Div_Rise = rise_q;
  assign Div_Ack      = ack_q;
  assign Div_Val_Cur  = cur_q;
  assign Div_Active   = running;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen; burst checks are compiled in
// when CLK_DIV_BURST_EN is defined.
module tb_clk_div_gen;

  logic        Clk_C16 = 1'b0;
  logic        Clk_C16_Rst_n;
  logic        Enable;
  logic [15:0] Div_Val;
  logic        Div_Load;
  logic        Div_Ack;
  logic [15:0] Div_Val_Cur;
  logic        Clk_Div_Out;
  logic        Clk_Div_Rise;
  logic        Div_Active;
`ifdef CLK_DIV_BURST_EN
  logic [15:0] Burst_Len;
  logic        Burst_Start;
  logic        Burst_Done;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 Clk_C16 = ~Clk_C16;

  clk_div_gen #(
    .CNT_W   (16),
    .DIV_RST (2)
  ) dut (
    .Clk_C16       (Clk_C16),
    .Clk_C16_Rst_n (Clk_C16_Rst_n),
    .Enable        (Enable),
    .Div_Val       (Div_Val),
    .Div_Load      (Div_Load),
    .Div_Ack       (Div_Ack),
    .Div_Val_Cur   (Div_Val_Cur),
    .Clk_Div_Out   (Clk_Div_Out),
    .Clk_Div_Rise  (Clk_Div_Rise),
    .Div_Active    (Div_Active)
`ifdef CLK_DIV_BURST_EN
    ,
    .Burst_Len     (Burst_Len),
    .Burst_Start   (Burst_Start),
    .Burst_Done    (Burst_Done)
`endif
  );

  task automatic tick;
    @(posedge Clk_C16);
    #1;
  endtask

  task automatic test_reset;
    Clk_C16_Rst_n = 1'b0;
    Enable        = 1'b0;
    Div_Load      = 1'b0;
    Div_Val       = 16'd0;
`ifdef CLK_DIV_BURST_EN
    Burst_Len     = 16'd0;
    Burst_Start   = 1'b0;
`endif
    repeat (3) tick();
    Clk_C16_Rst_n = 1'b1;
    tick();
    vec_cnt++; if (Clk_Div_Out !== 1'b0) begin err_cnt++; $display("FAIL reset_out: got %0b expected 0", Clk_Div_Out); end
    vec_cnt++; if (Clk_Div_Rise !== 1'b0) begin err_cnt++; $display("FAIL reset_rise: got %0b expected 0", Clk_Div_Rise); end
    vec_cnt++; if (Div_Ack !== 1'b0) begin err_cnt++; $display("FAIL reset_ack: got %0b expected 0", Div_Ack); end
    vec_cnt++; if (Div_Active !== 1'b0) begin err_cnt++; $display("FAIL reset_active: got %0b expected 0", Div_Active); end
    vec_cnt++; if (Div_Val_Cur !== 16'd2) begin err_cnt++; $display("FAIL reset_cur: got %0d expected 2", Div_Val_Cur); end
    $display("reset: out=%0b active=%0b cur=%0d", Clk_Div_Out, Div_Active, Div_Val_Cur);
  endtask

  task automatic test_run_n2;
    logic exp_v;
    Enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_v = ((i % 2) == 0);
      vec_cnt++; if (Clk_Div_Out !== exp_v) begin err_cnt++; $display("FAIL run2_out[%0d]: got %0b expected %0b", i, Clk_Div_Out, exp_v); end
      vec_cnt++; if (Clk_Div_Rise !== exp_v) begin err_cnt++; $display("FAIL run2_rise[%0d]: got %0b expected %0b", i, Clk_Div_Rise, exp_v); end
      vec_cnt++; if (Div_Active !== 1'b1) begin err_cnt++; $display("FAIL run2_active[%0d]: got %0b expected 1", i, Div_Active); end
      $display("run_n2 cycle %0d: out=%0b rise=%0b", i, Clk_Div_Out, Clk_Div_Rise);
    end
  endtask

  task automatic test_load5;
    logic e_out  [6];
    logic e_rise [6];
    logic e_ack  [6];
    e_out  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    e_rise = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    e_ack  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tick();
    Div_Val  = 16'd5;
    Div_Load = 1'b1;
    tick();
    Div_Load = 1'b0;
    vec_cnt++; if (Clk_Div_Out !== 1'b0) begin err_cnt++; $display("FAIL load5_oldperiod: got %0b expected 0", Clk_Div_Out); end
    vec_cnt++; if (Div_Val_Cur !== 16'd2) begin err_cnt++; $display("FAIL load5_early_cur: got %0d expected 2", Div_Val_Cur); end
    for (int i = 0; i < 6; i++) begin
      tick();
      vec_cnt++; if (Clk_Div_Out !== e_out[i]) begin err_cnt++; $display("FAIL load5_out[%0d]: got %0b expected %0b", i, Clk_Div_Out, e_out[i]); end
      vec_cnt++; if (Clk_Div_Rise !== e_rise[i]) begin err_cnt++; $display("FAIL load5_rise[%0d]: got %0b expected %0b", i, Clk_Div_Rise, e_rise[i]); end
      vec_cnt++; if (Div_Ack !== e_ack[i]) begin err_cnt++; $display("FAIL load5_ack[%0d]: got %0b expected %0b", i, Div_Ack, e_ack[i]); end
      $display("load5 cycle %0d: out=%0b rise=%0b ack=%0b cur=%0d", i, Clk_Div_Out, Clk_Div_Rise, Div_Ack, Div_Val_Cur);
    end
    vec_cnt++; if (Div_Val_Cur !== 16'd5) begin err_cnt++; $display("FAIL load5_cur: got %0d expected 5", Div_Val_Cur); end
  endtask

  task automatic test_clamp;
    logic e_out [8];
    logic e_ack [8];
    e_out = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    e_ack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    Div_Val  = 16'd0;
    Div_Load = 1'b1;
    tick();
    Div_Val  = 16'd1;
    tick();
    Div_Load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      vec_cnt++; if (Clk_Div_Out !== e_out[i]) begin err_cnt++; $display("FAIL clamp_out[%0d]: got %0b expected %0b", i, Clk_Div_Out, e_out[i]); end
      vec_cnt++; if (Div_Ack !== e_ack[i]) begin err_cnt++; $display("FAIL clamp_ack[%0d]: got %0b expected %0b", i, Div_Ack, e_ack[i]); end
      $display("clamp cycle %0d: out=%0b ack=%0b cur=%0d", i, Clk_Div_Out, Div_Ack, Div_Val_Cur);
    end
    vec_cnt++; if (Div_Val_Cur !== 16'd2) begin err_cnt++; $display("FAIL clamp_cur: got %0d expected 2", Div_Val_Cur); end
  endtask

  task automatic test_enable_glitch;
    logic e_out  [4];
    logic e_rise [4];
    e_out  = '{1'b0, 1'b0, 1'b1, 1'b1};
    e_rise = '{1'b0, 1'b0, 1'b1, 1'b0};
    // Load lands on the wrap cycle of the N=2 period.
    Div_Val  = 16'd4;
    Div_Load = 1'b1;
    tick();
    Div_Load = 1'b0;
    vec_cnt++; if (Div_Val_Cur !== 16'd4) begin err_cnt++; $display("FAIL wrapload_cur: got %0d expected 4", Div_Val_Cur); end
    vec_cnt++; if (Clk_Div_Rise !== 1'b1) begin err_cnt++; $display("FAIL wrapload_rise: got %0b expected 1", Clk_Div_Rise); end
    tick();
    vec_cnt++; if (Div_Ack !== 1'b1) begin err_cnt++; $display("FAIL wrapload_ack: got %0b expected 1", Div_Ack); end
    vec_cnt++; if (Clk_Div_Out !== 1'b1) begin err_cnt++; $display("FAIL wrapload_out: got %0b expected 1", Clk_Div_Out); end
    for (int i = 0; i < 4; i++) begin
      Enable = (i != 0);
      tick();
      vec_cnt++; if (Clk_Div_Out !== e_out[i]) begin err_cnt++; $display("FAIL glitch_out[%0d]: got %0b expected %0b", i, Clk_Div_Out, e_out[i]); end
      vec_cnt++; if (Clk_Div_Rise !== e_rise[i]) begin err_cnt++; $display("FAIL glitch_rise[%0d]: got %0b expected %0b", i, Clk_Div_Rise, e_rise[i]); end
      vec_cnt++; if (Div_Active !== 1'b1) begin err_cnt++; $display("FAIL glitch_active[%0d]: got %0b expected 1", i, Div_Active); end
      $display("glitch cycle %0d: en=%0b out=%0b rise=%0b", i, Enable, Clk_Div_Out, Clk_Div_Rise);
    end
  endtask

  task automatic test_stop;
    logic e_act [4];
    e_act = '{1'b1, 1'b1, 1'b0, 1'b0};
    Enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++; if (Clk_Div_Out !== 1'b0) begin err_cnt++; $display("FAIL stop_out[%0d]: got %0b expected 0", i, Clk_Div_Out); end
      vec_cnt++; if (Clk_Div_Rise !== 1'b0) begin err_cnt++; $display("FAIL stop_rise[%0d]: got %0b expected 0", i, Clk_Div_Rise); end
      vec_cnt++; if (Div_Active !== e_act[i]) begin err_cnt++; $display("FAIL stop_active[%0d]: got %0b expected %0b", i, Div_Active, e_act[i]); end
      $display("stop cycle %0d: out=%0b active=%0b", i, Clk_Div_Out, Div_Active);
    end
  endtask

  task automatic test_idle_load;
    logic e_ack [3];
    e_ack = '{1'b0, 1'b1, 1'b0};
    for (int rep = 0; rep < 2; rep++) begin
      Div_Val  = 16'd3;
      Div_Load = 1'b1;
      tick();
      Div_Load = 1'b0;
      if (rep == 0) begin
        vec_cnt++; if (Div_Val_Cur !== 16'd4) begin err_cnt++; $display("FAIL idleload_early_cur: got %0d expected 4", Div_Val_Cur); end
      end
      for (int i = 0; i < 3; i++) begin
        tick();
        vec_cnt++; if (Div_Ack !== e_ack[i]) begin err_cnt++; $display("FAIL idleload_ack[%0d.%0d]: got %0b expected %0b", rep, i, Div_Ack, e_ack[i]); end
        vec_cnt++; if (Div_Val_Cur !== 16'd3) begin err_cnt++; $display("FAIL idleload_cur[%0d.%0d]: got %0d expected 3", rep, i, Div_Val_Cur); end
        vec_cnt++; if (Clk_Div_Out !== 1'b0) begin err_cnt++; $display("FAIL idleload_out[%0d.%0d]: got %0b expected 0", rep, i, Clk_Div_Out); end
        $display("idle_load %0d cycle %0d: ack=%0b cur=%0d", rep, i, Div_Ack, Div_Val_Cur);
      end
    end
  endtask

  task automatic test_async_reset;
    Enable = 1'b1;
    tick();
    vec_cnt++; if (Clk_Div_Out !== 1'b1) begin err_cnt++; $display("FAIL arst_pre_out: got %0b expected 1", Clk_Div_Out); end
    #2;
    Clk_C16_Rst_n = 1'b0;
    #1;
    vec_cnt++; if (Clk_Div_Out !== 1'b0) begin err_cnt++; $display("FAIL arst_out: got %0b expected 0", Clk_Div_Out); end
    vec_cnt++; if (Clk_Div_Rise !== 1'b0) begin err_cnt++; $display("FAIL arst_rise: got %0b expected 0", Clk_Div_Rise); end
    vec_cnt++; if (Div_Active !== 1'b0) begin err_cnt++; $display("FAIL arst_active: got %0b expected 0", Div_Active); end
    vec_cnt++; if (Div_Val_Cur !== 16'd2) begin err_cnt++; $display("FAIL arst_cur: got %0d expected 2", Div_Val_Cur); end
    vec_cnt++; if (Div_Ack !== 1'b0) begin err_cnt++; $display("FAIL arst_ack: got %0b expected 0", Div_Ack); end
    $display("async reset: out=%0b active=%0b cur=%0d", Clk_Div_Out, Div_Active, Div_Val_Cur);
    Enable = 1'b0;
    repeat (2) tick();
    Clk_C16_Rst_n = 1'b1;
    tick();
    vec_cnt++; if (Clk_Div_Out !== 1'b0) begin err_cnt++; $display("FAIL arst_post_out: got %0b expected 0", Clk_Div_Out); end
  endtask

`ifdef CLK_DIV_BURST_EN
  task automatic test_burst;
    logic exp_o;
    logic exp_d;
    int   rises;
    Div_Val  = 16'd3;
    Div_Load = 1'b1;
    tick();
    Div_Load = 1'b0;
    repeat (3) tick();
    vec_cnt++; if (Div_Val_Cur !== 16'd3) begin err_cnt++; $display("FAIL burst_cur: got %0d expected 3", Div_Val_Cur); end
    rises       = 0;
    Burst_Len   = 16'd4;
    Burst_Start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      Burst_Start = 1'b0;
      exp_o = (i <= 12) && (((i - 1) % 3) == 0);
      exp_d = (i == 13);
      if (Clk_Div_Rise === 1'b1) rises++;
      vec_cnt++; if (Clk_Div_Out !== exp_o) begin err_cnt++; $display("FAIL burst_out[%0d]: got %0b expected %0b", i, Clk_Div_Out, exp_o); end
      vec_cnt++; if (Clk_Div_Rise !== exp_o) begin err_cnt++; $display("FAIL burst_rise[%0d]: got %0b expected %0b", i, Clk_Div_Rise, exp_o); end
      vec_cnt++; if (Burst_Done !== exp_d) begin err_cnt++; $display("FAIL burst_done[%0d]: got %0b expected %0b", i, Burst_Done, exp_d); end
      $display("burst cycle %0d: out=%0b rise=%0b done=%0b", i, Clk_Div_Out, Clk_Div_Rise, Burst_Done);
    end
    vec_cnt++; if (rises != 4) begin err_cnt++; $display("FAIL burst_rise_count: got %0d expected 4", rises); end
    Burst_Len   = 16'd0;
    Burst_Start = 1'b1;
    tick();
    Burst_Start = 1'b0;
    vec_cnt++; if (Burst_Done !== 1'b1) begin err_cnt++; $display("FAIL burst0_done: got %0b expected 1", Burst_Done); end
    vec_cnt++; if (Clk_Div_Out !== 1'b0) begin err_cnt++; $display("FAIL burst0_out: got %0b expected 0", Clk_Div_Out); end
    vec_cnt++; if (Div_Active !== 1'b0) begin err_cnt++; $display("FAIL burst0_active: got %0b expected 0", Div_Active); end
    tick();
    vec_cnt++; if (Burst_Done !== 1'b0) begin err_cnt++; $display("FAIL burst0_done_clear: got %0b expected 0", Burst_Done); end
    vec_cnt++; if (Clk_Div_Out !== 1'b0) begin err_cnt++; $display("FAIL burst0_out2: got %0b expected 0", Clk_Div_Out); end
    $display("burst len0: done pulse observed, out=%0b", Clk_Div_Out);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_run_n2();
    test_load5();
    test_clamp();
    test_enable_glitch();
    test_stop();
    test_idle_load();
    test_async_reset();
`ifdef CLK_DIV_BURST_EN
    test_burst();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
